// File: rtl/fp_div_sequencer_pkg.sv
// Shared single-precision field definitions, result flags and the
// operand classifier used by the divide sequencer.
package fp_div_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [XLEN-1:0]  QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
  } fp_flags_t;

  // How a result is produced once its tag leaves the pipeline
  typedef enum logic [1:0] {
    KIND_NORMAL  = 2'd0,
    KIND_INVALID = 2'd1,
    KIND_DIVZERO = 2'd2
  } op_kind_e;

  typedef struct packed {
    logic     valid;
    op_kind_e kind;
    logic     sign;
  } div_tag_t;

  // Decide at accept time whether the core quotient will be used or bypassed
  function automatic op_kind_e classify(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic a_zero, a_nan, a_inf;
    logic b_zero, b_nan, b_inf, b_exp_zero;
    a_zero     = (a[XLEN-2 -: EXP_W] == '0) && (a[MAN_W-1:0] == '0);
    a_inf      = (a[XLEN-2 -: EXP_W] == EXP_MAX) && (a[MAN_W-1:0] == '0);
    a_nan      = (a[XLEN-2 -: EXP_W] == EXP_MAX) && (a[MAN_W-1:0] != '0);
    b_exp_zero = (b[XLEN-2 -: EXP_W] == '0);
    b_zero     = b_exp_zero && (b[MAN_W-1:0] == '0);
    b_inf      = (b[XLEN-2 -: EXP_W] == EXP_MAX) && (b[MAN_W-1:0] == '0);
    b_nan      = (b[XLEN-2 -: EXP_W] == EXP_MAX) && (b[MAN_W-1:0] != '0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      return KIND_INVALID;
    if (b_exp_zero && !a_zero)
      return KIND_DIVZERO;
    return KIND_NORMAL;
  endfunction

endpackage

// File: rtl/fp_div_sequencer_fifo.sv
// First-word-fall-through result buffer with a registered occupancy count.
// Pointers wrap modulo DEPTH so any depth works, not just powers of two.
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];
  assign pop_ok    = pop && !empty;

  // Storage array; no reset so it maps onto plain memory
  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop_ok)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The upstream credit scheme must never let a push land on a full buffer
  always_ff @(posedge clk) begin
    if (rst_n)
      assert (!(push && full && !pop));
  end

endmodule

// File: rtl/fp_div_sequencer.sv
// Feeds operand pairs to an external fixed-latency divider, classifies
// special cases at accept time, and buffers in-order results with flags.
module fp_div_sequencer #(
  parameter int XLEN       = 32,
  parameter int DIV_LAT    = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [2:0]      out_flags
);
  import fp_div_sequencer_pkg::*;

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = XLEN + 3;

  logic             accept, pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] inflight_reg, fifo_count;
  logic [XLEN-1:0]  div_a_reg, div_b_reg, push_result;
  fp_flags_t        push_flags;
  div_tag_t         new_tag, issue_tag_reg, exit_tag;
  div_tag_t         pipe_tag_reg [DIV_LAT];
  logic [ENTRY_W-1:0] head_data;

  // Credits cover everything already committed to a buffer slot
  assign in_ready = ({1'b0, inflight_reg} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign accept   = in_valid && in_ready;
  assign div_a    = div_a_reg;
  assign div_b    = div_b_reg;

  // Tag for the pair being offered this cycle
  always_comb begin
    new_tag       = '0;
    new_tag.valid = accept;
    new_tag.kind  = classify(in_a, in_b);
    new_tag.sign  = in_a[XLEN-1] ^ in_b[XLEN-1];
  end

  // Issue stage: the tag register sits beside the div_a/div_b register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_a_reg     <= '0;
      div_b_reg     <= '0;
      issue_tag_reg <= '0;
    end else begin
      issue_tag_reg <= accept ? new_tag : '0;
      if (accept) begin
        div_a_reg <= in_a;
        div_b_reg <= in_b;
      end
    end
  end

  // Tag shift register: one stage per register stage inside the core
  for (genvar gi = 0; gi < DIV_LAT; gi++) begin : g_tag_pipe
    if (gi == 0) begin : g_first
      // First stage follows the issue register
      always_ff @(posedge clk) begin
        if (!rst_n) pipe_tag_reg[gi] <= '0;
        else        pipe_tag_reg[gi] <= issue_tag_reg;
      end
    end else begin : g_rest
      // Later stages shift the tag toward the quotient sample point
      always_ff @(posedge clk) begin
        if (!rst_n) pipe_tag_reg[gi] <= '0;
        else        pipe_tag_reg[gi] <= pipe_tag_reg[gi-1];
      end
    end
  end

  assign exit_tag = pipe_tag_reg[DIV_LAT-1];

  // Choose the buffered value: the core quotient or a bypassed constant
  always_comb begin
    push_result = div_q;
    push_flags  = '0;
    case (exit_tag.kind)
      KIND_INVALID: begin
        push_result        = QNAN;
        push_flags.invalid = 1'b1;
      end
      KIND_DIVZERO: begin
        push_result            = {exit_tag.sign, EXP_MAX, {MAN_W{1'b0}}};
        push_flags.div_by_zero = 1'b1;
      end
      default: push_flags.overflow = (div_q[XLEN-2 -: EXP_W] == EXP_MAX);
    endcase
  end

  // In-flight count: up on accept, down when a tag leaves the pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else begin
      case ({accept, exit_tag.valid})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (exit_tag.valid),
    .push_data ({push_flags, push_result}),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Outputs read as zero whenever nothing is buffered
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign out_result = out_valid ? head_data[XLEN-1:0] : '0;
  assign out_flags  = out_valid ? head_data[ENTRY_W-1 -: 3] : 3'b000;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed bench for fp_div_sequencer with a behavioural pipelined divider.
`timescale 1ns/1ps
module tb_fp_div_sequencer;
  localparam int XLEN       = 32;
  localparam int DIV_LAT    = 12;
  localparam int FIFO_DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic [XLEN-1:0] div_a, div_b, div_q;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic [2:0]      out_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_div_sequencer #(
    .XLEN       (XLEN),
    .DIV_LAT    (DIV_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_q      (div_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // Behavioural divider for normal operands; anything else returns junk
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e11;
    e11 = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e11, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 32'hDEAD_BEEF;
    return r2f(f2r(a) / f2r(b));
  endfunction

  logic [31:0] core_pipe [DIV_LAT];
  always @(posedge clk) begin
    core_pipe[0] <= model_div(div_a, div_b);
    for (int i = 1; i < DIV_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign div_q = core_pipe[DIV_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("send_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("send a=%h b=%h", a, b);
  endtask

  task automatic recv(input string tag, input logic [31:0] exp_r, input logic [2:0] exp_f);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, out_result, exp_r);
    chk({tag, "_flags"}, {29'b0, out_flags}, {29'b0, exp_f});
    $display("recv %s result=%h flags=%b", tag, out_result, out_flags);
    @(posedge clk); #1;
  endtask

  logic [31:0] fill_a [4];
  logic [31:0] fill_q [4];
  int          n, acc, seen;
  logic        r;

  initial begin
    fill_a = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};
    fill_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", {29'b0, out_flags}, 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Minimum latency: 6 / 2
    in_valid = 1'b1; in_a = 32'h40C0_0000; in_b = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("div_a_hold", div_a, 32'h40C0_0000);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("lat_edges", 32'(n), 32'(DIV_LAT + 1));
    chk("lat_result", out_result, 32'h4040_0000);
    chk("lat_flags", {29'b0, out_flags}, 32'd0);
    $display("latency edges=%0d result=%h", n, out_result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("lat_popped", {31'b0, out_valid}, 32'd0);

    // Divide by zero with both signs
    send(32'h3F80_0000, 32'h0000_0000);
    send(32'hBF80_0000, 32'h0000_0000);
    recv("dz_pos", 32'h7F80_0000, 3'b010);
    recv("dz_neg", 32'hFF80_0000, 3'b010);

    // Invalid cases interleaved with normal divides
    send(32'h0000_0000, 32'h0000_0000);
    send(32'h40C0_0000, 32'h4000_0000);
    send(32'h7FC0_0000, 32'h3F80_0000);
    send(32'h3F80_0000, 32'h4000_0000);
    recv("inv_zz", 32'h7FC0_0000, 3'b100);
    recv("mix_n1", 32'h4040_0000, 3'b000);
    recv("inv_nan", 32'h7FC0_0000, 3'b100);
    recv("mix_n2", 32'h3F00_0000, 3'b000);

    // Overflow reported by the core
    send(32'h7F00_0000, 32'h3E80_0000);
    recv("ovf", 32'h7F80_0000, 3'b001);

    // Back-pressure: only FIFO_DEPTH pairs accepted while the output stalls
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1; in_b = 32'h4000_0000;
    for (int c = 0; c < 30; c++) begin
      in_a = fill_a[(acc < 4) ? acc : 3];
      r = in_ready;
      @(posedge clk); #1;
      if (r) acc++;
    end
    in_valid = 1'b0;
    $display("backpressure accepts=%0d", acc);
    chk("full_accepts", 32'(acc), 32'(FIFO_DEPTH));
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_head", out_result, fill_q[0]);
    @(posedge clk); #1;
    chk("full_head_hold", out_result, fill_q[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", {31'b0, out_valid}, 32'd1);
      chk("drain_result", out_result, fill_q[k]);
      $display("drain %0d result=%h", k, out_result);
      @(posedge clk); #1;
      if (k == 0) chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
    end
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Reset while three operations are in flight
    send(32'h40C0_0000, 32'h4000_0000);
    send(32'h40C0_0000, 32'h4000_0000);
    send(32'h40C0_0000, 32'h4000_0000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 3 * DIV_LAT; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    $display("reset flush valid_cycles=%0d", seen);

    // Fresh operation after reset: 1 / 2
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("post_rst_edges", 32'(n), 32'(DIV_LAT + 1));
    chk("post_rst_result", out_result, 32'h3F00_0000);
    chk("post_rst_flags", {29'b0, out_flags}, 32'd0);
    $display("post reset edges=%0d result=%h", n, out_result);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
